// File: rtl/audio_i2s_transmitter_pkg.sv
// Shared constants, FSM encoding and slot bit mapping for the I2S transmitter.
// Frame = two DATA_BITS slots; left slot first, MSB one bclk after the lrclk edge.
package audio_i2s_transmitter_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BITS  = 2 * SAMPLE_BITS;

  typedef enum logic [1:0] {
    I2S_IDLE  = 2'd0,
    I2S_PRIME = 2'd1,
    I2S_RUN   = 2'd2
  } i2s_state_e;

  // Word bit index presented while bit_cnt == b; bit 0 carries the previous word's LSB.
  function automatic int slot_bit(input int b, input int data_bits);
    if (b == 0)
      return 0;
    else if (b <= data_bits)
      return data_bits - b;
    else
      return 2 * data_bits - b;
  endfunction

endpackage

// File: rtl/audio_i2s_transmitter_sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout is valid whenever empty is low.
// Zero-latency read, one-cycle write; push on full is ignored unless a pop frees the slot, pop on empty ignored.
module sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (level == (ADDR_BITS + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_i2s_transmitter.sv
// Buffers equalizer samples and serializes each as a mono Philips-I2S frame (same word in both slots).
// MSB leaves 1 bclk after the frame boundary that pops it; writes into a full FIFO are dropped and flagged.
module audio_i2s_transmitter
  import audio_i2s_transmitter_pkg::*;
#(
  parameter int DATA_BITS      = SAMPLE_BITS,
  parameter int BCLK_DIV       = 1,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DATA_BITS-1:0]      sample_in,
  input  logic                      sample_valid,
  input  logic                      clear_flags,
  output logic                      fifo_full,
  output logic [FIFO_ADDR_BITS:0]   fifo_level,
  output logic                      overflow,
  output logic                      underrun,
  output logic                      bclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      frame_start
);

  localparam int FRAME_LEN = 2 * DATA_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int DIV_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IDX_W     = $clog2(DATA_BITS);

  i2s_state_e           state_q, state_d;
  logic [DIV_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     bit_cnt, bit_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] word, fifo_dout;
  logic                 fifo_empty, stop_pend;
  logic                 div_wrap, fall_evt, boundary, push, pop;

  assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_evt = (state_q == I2S_RUN) && bclk && div_wrap;
  assign boundary = fall_evt && (bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign pop      = boundary && enable;
  assign push     = sample_valid && (!fifo_full || pop);
  assign bit_nxt  = (bit_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + 1'b1;
  assign bit_idx  = IDX_W'(slot_bit(int'(bit_nxt), DATA_BITS));

  sync_fifo #(
    .WIDTH     (DATA_BITS),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= I2S_IDLE;
    else      state_q <= state_d;
  end

  // A disabled boundary still lets bit 0 (right LSB) be clocked out before stopping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      I2S_IDLE:  if (enable) state_d = I2S_PRIME;
      I2S_PRIME: if (fifo_level != '0) state_d = I2S_RUN;
      I2S_RUN:   if (fall_evt && stop_pend) state_d = I2S_IDLE;
      default:   state_d = I2S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      word        <= '0;
      stop_pend   <= 1'b0;
    end else begin
      frame_start <= pop;
      if (state_q != I2S_RUN || state_d == I2S_IDLE) begin
        div_cnt   <= '0;
        bclk      <= 1'b0;
        stop_pend <= 1'b0;
        // Preloading the last bit makes the first fall event of a run a frame boundary.
        bit_cnt   <= (state_d == I2S_RUN) ? CNT_W'(FRAME_LEN - 1) : '0;
        if (state_q == I2S_RUN) begin
          lrclk <= 1'b0;
          sdata <= 1'b0;
        end
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        if (div_wrap) bclk <= ~bclk;
        if (fall_evt) begin
          bit_cnt <= bit_nxt;
          lrclk   <= (bit_nxt >= CNT_W'(DATA_BITS));
          sdata   <= word[bit_idx];
        end
        if (boundary) stop_pend <= ~enable;
        if (pop)      word      <= fifo_empty ? '0 : fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (sample_valid && !push) overflow <= 1'b1;
      else if (clear_flags)      overflow <= 1'b0;
      if (pop && fifo_empty)     underrun <= 1'b1;
      else if (clear_flags)      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Directed + random bench: an I2S receiver decodes the serial stream and compares it with a queue model.
module tb_audio_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        clear_flags;
  logic        fifo_full;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underrun;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;

  always #5 clk = ~clk;

  audio_i2s_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] mq[$];
  logic [15:0] exp_words[$];
  logic        exp_overflow = 1'b0;
  logic        exp_underrun = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Model of the sample buffer: depth 4, writes beyond that are lost.
  task automatic write_sample(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    if (mq.size() < 4) mq.push_back(v);
    else exp_overflow = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic expect_idle(input string tag, input int n);
    int highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (bclk !== 1'b0) highs++;
    end
    chk(tag, 32'(highs), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_flags  = 1'b1;
    exp_overflow = 1'b0;
    exp_underrun = 1'b0;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  // I2S receiver: a bit belongs to the slot whose lrclk was seen on the previous bclk rise.
  logic        prev_bclk = 1'b0, armed = 1'b0, collecting = 1'b0;
  logic        prev_lr = 1'b0, cur_slot = 1'b0, exp_slot = 1'b0, fs_valid = 1'b0;
  logic [15:0] shreg = '0;
  logic [15:0] popped;
  int          nbits = 0, low_run = 0, last_fs = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b1) begin
      armed = 1'b0; collecting = 1'b0; fs_valid = 1'b0; low_run = 0; prev_bclk = 1'b0;
    end else begin
      if (bclk && !prev_bclk && armed) begin
        if (collecting) begin
          shreg = {shreg[14:0], sdata};
          nbits++;
          if (nbits == 16) begin
            collecting = 1'b0;
            chk("slot_order", 32'(cur_slot), 32'(exp_slot));
            exp_slot = ~cur_slot;
            chk("word_pending", 32'(exp_words.size() != 0), 32'd1);
            if (exp_words.size() != 0) begin
              if (cur_slot) begin
                chk("right_word", 32'(shreg), 32'(exp_words[0]));
                popped = exp_words.pop_front();
              end else begin
                chk("left_word", 32'(shreg), 32'(exp_words[0]));
              end
            end
          end
        end
        if (lrclk != prev_lr) begin
          collecting = 1'b1;
          nbits      = 0;
          cur_slot   = lrclk;
        end
        prev_lr = lrclk;
      end
      if (frame_start === 1'b1) begin
        if (mq.size() > 0) exp_words.push_back(mq.pop_front());
        else begin
          exp_words.push_back(16'h0000);
          exp_underrun = 1'b1;
        end
        if (fs_valid) chk("frame_period", 32'(cyc - last_fs), 32'd64);
        fs_valid = 1'b1;
        last_fs  = cyc;
        if (!armed) begin
          armed = 1'b1; prev_lr = 1'b1; collecting = 1'b0; exp_slot = 1'b0;
        end
      end
      low_run = (bclk === 1'b1) ? 0 : low_run + 1;
      if (low_run >= 3) begin
        armed = 1'b0; fs_valid = 1'b0;
      end
      prev_bclk = bclk;
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sample_in = '0; sample_valid = 1'b0; clear_flags = 1'b0;
    #2 rst = 1'b0;

    // Reset: strobes are ignored and every output stays low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_in    = 16'($urandom);
      sample_valid = ~sample_valid;
      chk("rst_level", 32'(fifo_level), 32'd0);
    end
    sample_valid = 1'b0;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_flags", 32'({overflow, underrun, fifo_full}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single word, then empty frames carrying zeros and raising underrun.
    enable = 1'b1;
    write_sample(16'hA5C3);
    wait_fs("fs_first");
    chk("no_underrun_yet", 32'(underrun), 32'(exp_underrun));
    wait_fs("fs_empty1");
    wait_fs("fs_empty2");
    @(negedge clk);
    chk("underrun_set", 32'(underrun), 32'(exp_underrun));
    chk("underrun_model", 32'(exp_underrun), 32'd1);

    // Drop enable mid-frame; the frame finishes, then bclk parks low.
    wait_fs("fs_before_stop");
    repeat (14) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    expect_idle("idle_after_stop", 20);
    chk("drained_stop", 32'(exp_words.size()), 32'd0);
    write_sample(16'h8001);
    enable = 1'b1;
    wait_fs("fs_8001");
    enable = 1'b0;
    repeat (90) @(negedge clk);
    chk("drained_8001", 32'(exp_words.size()), 32'd0);
    expect_idle("idle_after_8001", 5);

    // Overflow while idle, then flag clear and drain of exactly four words.
    for (int i = 0; i < 5; i++) write_sample(16'($urandom));
    chk("ovf_level", 32'(fifo_level), 32'(mq.size()));
    chk("ovf_full", 32'(fifo_full), 32'(mq.size() == 4));
    chk("ovf_flag", 32'(overflow), 32'(exp_overflow));
    pulse_clear();
    chk("clr_overflow", 32'(overflow), 32'(exp_overflow));
    chk("clr_underrun", 32'(underrun), 32'(exp_underrun));
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_fs("fs_drain");
    enable = 1'b0;
    repeat (90) @(negedge clk);
    chk("drained_four", 32'(exp_words.size()), 32'd0);
    chk("no_underrun_four", 32'(underrun), 32'(exp_underrun));
    chk("level_four", 32'(fifo_level), 32'(mq.size()));

    // Asynchronous reset in the right slot, then PRIME holds until data arrives.
    enable = 1'b1;
    write_sample(16'($urandom));
    wait_fs("fs_pre_reset");
    repeat (40) @(negedge clk);
    chk("lrclk_right_slot", 32'(lrclk), 32'd1);
    rst = 1'b0;
    mq.delete(); exp_words.delete(); exp_overflow = 1'b0; exp_underrun = 1'b0;
    #1;
    chk("arst_outputs", 32'({bclk, lrclk, sdata, frame_start}), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'(mq.size()));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_idle("prime_waits", 30);
    chk("prime_level", 32'(fifo_level), 32'(mq.size()));
    write_sample(16'($urandom));
    wait_fs("fs_after_reset");
    enable = 1'b0;
    repeat (90) @(negedge clk);
    chk("drained_reset", 32'(exp_words.size()), 32'd0);

    // Random traffic: 0..2 writes per frame, mixing underrun and overflow.
    pulse_clear();
    enable = 1'b1;
    write_sample(16'($urandom));
    for (int f = 0; f < 8; f++) begin
      int n;
      wait_fs("fs_random");
      repeat (20) @(negedge clk);
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) write_sample(16'($urandom));
    end
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("drained_random", 32'(exp_words.size()), 32'd0);
    chk("rand_level", 32'(fifo_level), 32'(mq.size()));
    chk("rand_full", 32'(fifo_full), 32'(mq.size() == 4));
    chk("rand_overflow", 32'(overflow), 32'(exp_overflow));
    chk("rand_underrun", 32'(underrun), 32'(exp_underrun));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
